counter_chain_ctrl: RTL
=======================

// Module: counter_chain_ctrl
// PURPOSE
//   Sequencer for a chain of NDIG 4-bit load/up-down digit counters (BCD or hex).
//   Owns the prescaler that paces counting, the per-digit cascade enables and the load sequence.
//   It reads back all digit values and drives one-hot load strobes.
//   Sits between board switches/buttons and the digit counters feeding the 7-seg display mux.
// PARAMETERS
//   NDIG     4          number of chained digits (1..8)
//   TICK_DIV 100000000  clk cycles per count tick (>=2); 1 Hz at 100 MHz
//   DIV_W    27         prescaler width, must satisfy 2**DIV_W >= TICK_DIV
//   IDX_W    2          width of load_idx
// PORTS
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, ACTIVE-LOW
//   run        in   1        1 = count, 0 = hold (level)
//   sel        in   1        1 = BCD digits (0..9), 0 = hex digits (0..15)
//   updown     in   1        1 = count up, 0 = count down
//   load_req   in   1        load button, already debounced and synchronous; acts on rising edge
//   load_idx   in   IDX_W    digit to load, 0 = least significant
//   digits     in   4*NDIG   current digit values from counters, digit i at [4i+3:4i]
//   dig_en     out  NDIG     per-digit count enable
//   dig_load   out  NDIG     per-digit one-hot load strobe; counters load from the load-value switches
//   tick       out  1        prescaler tick
//   rollover   out  1        whole chain wraps this cycle
//   busy       out  1        load sequence in progress
// BEHAVIOUR
//   Reset (rst=0, async): state=STOP, div_cnt=0, load_q=0; dig_en, dig_load, tick, rollover and busy all 0.
//   States: STOP, RUN, LOAD, WAIT_REL (2-bit registered).
//   Edge detect: rise = load_req & ~load_q; load_q is registered every cycle.
//   STOP:
//     - div_cnt held at 0.
//     - rise -> LOAD; else run=1 -> RUN.
//   RUN:
//     - div_cnt counts 0..TICK_DIV-1, then wraps to 0.
//     - tick = (div_cnt==TICK_DIV-1) & ~rise, combinational from registers.
//     - rise -> LOAD (tick masked in that cycle); else run=0 -> STOP, div_cnt cleared.
//   LOAD:
//     - Exactly one cycle: dig_load[load_idx]=1 if load_idx<NDIG, else all 0 (ignored).
//     - div_cnt cleared; -> WAIT_REL.
//   WAIT_REL:
//     - Stay while load_req=1.
//     - On load_req=0: -> RUN if run, else STOP.
//     - A new rise needs a release first.
//   busy = 1 in LOAD and WAIT_REL.
//   Terminal value: up -> 9 (sel=1) or 15 (sel=0); down -> 0 in both modes.
//   Digit above 9 in BCD mode is never terminal when counting up.
//   Cascade:
//     - dig_en[0] = tick.
//     - dig_en[i] = tick & (digits[0..i-1] all at terminal).
//   rollover = tick & all NDIG digits terminal.
//   dig_en, tick and rollover are 0 in STOP, LOAD and WAIT_REL; dig_en and dig_load are never both set.
//   sel/updown changes take effect on the next tick; no resync, no flush.
//   Latency:
//     - First tick comes TICK_DIV cycles after entering RUN.
//     - dig_load comes 1 cycle after the rise cycle.
// TESTING (NDIG=2, TICK_DIV=4, behavioural digit model)
//   rst=0 mid-LOAD -> all outputs 0 immediately; after release: STOP, no dig_load pulse.
//   BCD up, digits=00, run=1 -> dig_en=01 every 4th cycle; at 09, tick gives dig_en=11; at 99, rollover=1 -> 00.
//   Hex down, digits=00 -> dig_en=11 and rollover=1 on tick; model shows FF.
//   load_idx=1, load_req rises (held 5 cycles) -> next cycle dig_load=10 for 1 cycle; busy=1 until release; dig_en=00 throughout.
//   load_req rises in the cycle div_cnt=3 -> tick=0 that cycle; after release the next tick comes 4 cycles after re-entering RUN.
//   load_idx=3 -> dig_load stays 00; busy pulses; FSM returns to RUN.

Source files
------------

// File: rtl/counter_chain_ctrl.sv
// Sequencer for a chain of 4-bit digit counters: paces counting with a prescaler,
// computes the cascade enables and runs a one-shot load strobe per button press.
module counter_chain_ctrl #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 100000000,
  parameter int DIV_W    = 27,
  parameter int IDX_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sel,
  input  logic              updown,
  input  logic              load_req,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_en,
  output logic [NDIG-1:0]   dig_load,
  output logic              tick,
  output logic              rollover,
  output logic              busy
);

  typedef enum logic [1:0] {STOP, RUN, LOAD, WAIT_REL} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             load_q_reg;
  logic             rise;
  logic             div_last;
  logic [NDIG-1:0]  term;
  logic [NDIG-1:0]  idx_hit;
  logic [NDIG:0]    chain;

  assign rise     = load_req & ~load_q_reg;
  assign div_last = (div_cnt_reg == DIV_W'(TICK_DIV - 1));

  // chain[i] is set when every digit below i sits at its terminal value
  assign chain[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign term[gi] = updown ? (sel ? (digits[4*gi +: 4] == 4'd9) : (digits[4*gi +: 4] == 4'hF))
                               : (digits[4*gi +: 4] == 4'd0);
      assign chain[gi+1] = chain[gi] & term[gi];
      assign idx_hit[gi] = (load_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= STOP;
      div_cnt_reg <= '0;
      load_q_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      load_q_reg  <= load_req;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    tick         = 1'b0;
    busy         = 1'b0;
    dig_load     = '0;
    case (state_reg)
      STOP: begin
        div_cnt_next = '0;
        if (rise)     state_next = LOAD;
        else if (run) state_next = RUN;
      end
      RUN: begin
        // a press in the tick cycle swallows that tick
        tick = div_last & ~rise;
        if (rise) begin
          state_next   = LOAD;
          div_cnt_next = '0;
        end else if (!run) begin
          state_next   = STOP;
          div_cnt_next = '0;
        end else begin
          div_cnt_next = div_last ? '0 : div_cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        busy         = 1'b1;
        dig_load     = idx_hit;
        div_cnt_next = '0;
        state_next   = WAIT_REL;
      end
      WAIT_REL: begin
        busy         = 1'b1;
        div_cnt_next = '0;
        if (!load_req) state_next = run ? RUN : STOP;
      end
      default: state_next = STOP;
    endcase
  end

  assign dig_en   = {NDIG{tick}} & chain[NDIG-1:0];
  assign rollover = tick & chain[NDIG];

endmodule
